// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, then
// shifts one byte plus odd parity out on device-generated clocks and checks the ACK.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ     = 3500000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_MS = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INHIBIT_CYC = 32'((64'(CLK_HZ) * 64'(INHIBIT_US)) / 64'd1000000);
    localparam int unsigned TO_CYC      = 32'((64'(CLK_HZ) * 64'(TIMEOUT_MS)) / 64'd1000);
    localparam int unsigned CW          = $clog2(TO_CYC + 1);

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] TO_LAST      = CW'(TO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_n;
    logic [8:0]    r_shift;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic          r_clk_oe;
    logic          r_dat_oe;

    logic          r_clk_meta;
    logic          r_clk_sync;
    logic          r_clk_prev;
    logic          r_dat_meta;
    logic          r_dat_sync;

    state_t        w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [3:0]    w_n_nx;
    logic [8:0]    w_shift_nx;
    logic          w_busy_nx;
    logic          w_done_nx;
    logic          w_error_nx;
    logic          w_clk_oe_nx;
    logic          w_dat_oe_nx;

    logic          w_fe;
    logic          w_timeout;
    logic          w_timed_state;

    assign w_fe          = r_clk_prev & ~r_clk_sync;
    assign w_timeout     = (r_cnt == TO_LAST);
    assign w_timed_state = (r_state == S_RTS) || (r_state == S_SEND) ||
                           (r_state == S_ACK) || (r_state == S_WAIT_IDLE);

    // Synchronisers idle high so reset never manufactures a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_in;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_dat_in;
            r_dat_sync <= r_dat_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_n      <= '0;
            r_shift  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_n      <= w_n_nx;
            r_shift  <= w_shift_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_error  <= w_error_nx;
            r_clk_oe <= w_clk_oe_nx;
            r_dat_oe <= w_dat_oe_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_n_nx      = r_n;
        w_shift_nx  = r_shift;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_error_nx  = 1'b0;
        w_clk_oe_nx = r_clk_oe;
        w_dat_oe_nx = r_dat_oe;

        if (w_timed_state) begin
            w_cnt_nx = r_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nx = 1'b0;
                w_dat_oe_nx = 1'b0;
                w_busy_nx   = 1'b0;
                if (tx_start) begin
                    w_shift_nx  = {~^tx_data, tx_data};
                    w_busy_nx   = 1'b1;
                    w_clk_oe_nx = 1'b1;
                    w_cnt_nx    = '0;
                    w_n_nx      = '0;
                    w_state_nx  = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (r_cnt == INHIBIT_LAST) begin
                    w_dat_oe_nx = 1'b1;
                    w_cnt_nx    = '0;
                    w_state_nx  = S_RTS;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end

            // Data was pulled low on entry while the clock was still held; release clock now.
            S_RTS: begin
                w_clk_oe_nx = 1'b0;
                w_n_nx      = '0;
                w_state_nx  = S_SEND;
            end

            S_SEND: begin
                if (w_fe) begin
                    if (r_n == 4'd9) begin
                        w_dat_oe_nx = 1'b0;
                        w_n_nx      = 4'd10;
                        w_state_nx  = S_ACK;
                    end else begin
                        w_dat_oe_nx = ~r_shift[r_n];
                        w_n_nx      = r_n + 4'd1;
                    end
                end
            end

            S_ACK: begin
                if (w_fe) begin
                    if (!r_dat_sync) begin
                        w_state_nx = S_WAIT_IDLE;
                    end else begin
                        w_error_nx = 1'b1;
                        w_busy_nx  = 1'b0;
                        w_cnt_nx   = '0;
                        w_state_nx = S_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (r_clk_sync && r_dat_sync) begin
                    w_done_nx  = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_clk_oe_nx = 1'b0;
                w_dat_oe_nx = 1'b0;
                w_busy_nx   = 1'b0;
                w_cnt_nx    = '0;
                w_state_nx  = S_IDLE;
            end
        endcase

        // Timeout overrides whatever the state logic decided this cycle, including an ACK.
        if (w_timed_state && w_timeout) begin
            w_clk_oe_nx = 1'b0;
            w_dat_oe_nx = 1'b0;
            w_busy_nx   = 1'b0;
            w_done_nx   = 1'b0;
            w_error_nx  = 1'b1;
            w_cnt_nx    = '0;
            w_n_nx      = '0;
            w_state_nx  = S_IDLE;
        end
    end

    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign tx_error   = r_error;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames out, and
// captured bits and completion pulses are checked against queued expectations.
module tb_ps2_host_tx;

    localparam int unsigned SPEC_HALF = 140;  // 12.5 kHz device clock at 3.5 MHz
    localparam int unsigned FAST_HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .CLK_HZ    (3500000),
        .INHIBIT_US(100),
        .TIMEOUT_MS(15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          exp_bits[$];
    int          exp_out[$];
    int unsigned n_done = 0;
    int unsigned n_err = 0;
    int unsigned rts_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outcome codes: 1 = tx_done, 2 = tx_error, 3 = both at once.
    always @(negedge clk) begin
        if (tx_done || tx_error) begin
            int code;
            code = {30'd0, tx_error, tx_done};
            if (tx_done) n_done++;
            if (tx_error) n_err++;
            if (exp_out.size() == 0) check("unexpected_pulse", 32'(code), 32'd0);
            else check("outcome", 32'(code), 32'(exp_out.pop_front()));
            check("busy_at_pulse", 32'(tx_busy), 32'd0);
            check("oe_at_pulse", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        end
    end

    task automatic push_frame(input logic [7:0] d);
        int unsigned ones = 0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        exp_bits.push_back((ones % 2) == 0);
        exp_bits.push_back(1'b1);
    endtask

    task automatic start_tx(input logic [7:0] d, input int outcome, input bit with_bits);
        int unsigned hi = 0;
        int unsigned g = 0;
        if (with_bits) push_frame(d);
        if (outcome != 0) exp_out.push_back(outcome);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
        check("busy_after_start", 32'(tx_busy), 32'd1);
        while (!ps2_dat_oe && g < 2000) begin
            if (ps2_clk_oe) hi++;
            g++;
            @(negedge clk);
        end
        check("inhibit_cycles", hi, 32'd350);
        check("clk_held_at_rts", 32'(ps2_clk_oe), 32'd1);
        rts_cyc = cyc;
        @(negedge clk);
        check("clk_released_after_rts", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd1);
    endtask

    task automatic dev_frame(input bit ack, input int unsigned nclk, input int unsigned half);
        int unsigned g = 0;
        bit b;
        while (!(ps2_clk_in && !ps2_dat_in) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("rts_seen", 32'(ps2_clk_in && !ps2_dat_in), 32'd1);
        for (int unsigned k = 1; k <= nclk; k++) begin
            repeat (half) @(negedge clk);
            b = ps2_dat_in;
            if (exp_bits.size() == 0) check("frame_bit_extra", 32'(b), 32'd2);
            else check($sformatf("frame_bit%0d", k - 1), 32'(b), 32'(exp_bits.pop_front()));
            if (k == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (10) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            if (k == nclk && nclk < 11) return;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        repeat (half) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag);
        int unsigned g = 0;
        while (tx_busy && g < 60000) begin
            @(negedge clk);
            g++;
        end
        check(tag, 32'(tx_busy), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic good_send(input logic [7:0] d, input int unsigned half, input string tag);
        int unsigned d0;
        d0 = n_done;
        start_tx(d, 1, 1'b1);
        dev_frame(1'b1, 11, half);
        wait_not_busy({tag, "_finish"});
        check({tag, "_done_count"}, n_done - d0, 32'd1);
        check({tag, "_bits_left"}, exp_bits.size(), 32'd0);
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0;
        int unsigned e0;
        int unsigned g;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_error", 32'(tx_error), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        good_send(8'hED, SPEC_HALF, "ed");
        good_send(8'h01, FAST_HALF, "x01");
        good_send(8'hFF, FAST_HALF, "xff");

        // No ACK from the device.
        d0 = n_done;
        e0 = n_err;
        start_tx(8'hF3, 2, 1'b1);
        dev_frame(1'b0, 11, FAST_HALF);
        wait_not_busy("nack_finish");
        check("nack_error_count", n_err - e0, 32'd1);
        check("nack_done_count", n_done - d0, 32'd0);
        check("nack_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);

        // Device never clocks.
        e0 = n_err;
        start_tx(8'hED, 2, 1'b0);
        g = 0;
        while (!tx_error && g < 60000) begin
            @(negedge clk);
            g++;
        end
        check("timeout_cycles", cyc - rts_cyc, 32'd52500);
        check("timeout_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        repeat (3) @(negedge clk);
        check("timeout_error_count", n_err - e0, 32'd1);

        // tx_start mid-frame must be ignored.
        d0 = n_done;
        start_tx(8'hED, 1, 1'b1);
        fork
            dev_frame(1'b1, 11, FAST_HALF);
            begin
                repeat (300) @(negedge clk);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                tx_data  = 8'h00;
            end
        join
        wait_not_busy("ignore_finish");
        repeat (500) @(negedge clk);
        check("ignore_done_count", n_done - d0, 32'd1);
        check("ignore_idle_busy", 32'(tx_busy), 32'd0);
        check("ignore_idle_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);

        // Reset mid-frame after the fourth falling edge.
        d0 = n_done;
        e0 = n_err;
        start_tx(8'hED, 0, 1'b1);
        dev_frame(1'b1, 4, FAST_HALF);
        repeat (6) @(negedge clk);
        check("busy_before_reset", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        exp_bits.delete();
        repeat (400) @(negedge clk);
        check("midrst_no_done", n_done - d0, 32'd0);
        check("midrst_no_error", n_err - e0, 32'd0);
        check("midrst_idle_busy", 32'(tx_busy), 32'd0);

        good_send(8'hED, FAST_HALF, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
